// File: rtl/handshake_rx.sv
// Four-phase handshake receiver: synchronizes t_rdy into tclk, acknowledges each
// transaction with r_ack and queues the transmitted word in a show-ahead FIFO.
module handshake_rx #(
  parameter int DEPTH = 4
) (
  input  logic                     tclk,
  input  logic                     resetb_tclk,
  input  logic                     t_rdy,
  input  logic [31:0]              t_data,
  output logic                     r_ack,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic                     rx_empty,
  output logic                     rx_full,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     rd_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic {IDLE_R, ACK_R} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_sync1;
  logic            r_sync2;
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic            r_underflow;
  logic [31:0]     r_mem [DEPTH];
  logic            w_doWrite;
  logic            w_doPop;

  assign rx_empty     = (r_count == '0);
  assign rx_full      = (r_count == CNT_FULL);
  assign rx_count     = r_count;
  assign rd_data      = r_mem[r_rdPtr];
  assign rd_underflow = r_underflow;
  assign r_ack        = (r_state == ACK_R);

  // A full FIFO simply holds off the write; the transmitter stays stalled with r_ack low.
  assign w_doWrite = (r_state == IDLE_R) && r_sync2 && !rx_full;
  assign w_doPop   = rd_en && !rx_empty;

  always_ff @(posedge tclk or negedge resetb_tclk) begin
    if (!resetb_tclk) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE_R;
    end else begin
      r_sync1 <= t_rdy;
      r_sync2 <= r_sync1;
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE_R:  if (w_doWrite) w_nextState = ACK_R;
      ACK_R:   if (!r_sync2) w_nextState = IDLE_R;
      default: w_nextState = IDLE_R;
    endcase
  end

  always_ff @(posedge tclk or negedge resetb_tclk) begin
    if (!resetb_tclk) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= rd_en && rx_empty;
      if (w_doWrite) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)   r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_doWrite, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately unreset; rd_data is meaningless while empty.
  always_ff @(posedge tclk) begin
    if (w_doWrite) r_mem[r_wrPtr] <= t_data;
  end

endmodule

// File: tb/tb_handshake_rx.sv
// Randomized self-checking bench for handshake_rx; a word queue models the FIFO
// and the bench plays the four-phase transmitter and the consumer.
module tb_handshake_rx;

  localparam int DEPTH = 4;

  logic        tclk = 1'b0;
  logic        resetb_tclk;
  logic        t_rdy;
  logic [31:0] t_data;
  logic        r_ack;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rx_empty;
  logic        rx_full;
  logic [2:0]  rx_count;
  logic        rd_underflow;

  int checks = 0;
  int failures = 0;
  logic [31:0] expQ[$];

  handshake_rx #(.DEPTH(DEPTH)) dut (
    .tclk(tclk), .resetb_tclk(resetb_tclk), .t_rdy(t_rdy), .t_data(t_data),
    .r_ack(r_ack), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
    .rx_full(rx_full), .rx_count(rx_count), .rd_underflow(rd_underflow)
  );

  always #5 tclk = ~tclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  task automatic waitAck(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (r_ack === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full four-phase transaction; the model gains the word once r_ack is seen high.
  task automatic sendWord(input logic [31:0] d, output bit ok);
    bit okHi, okLo;
    t_data = d;
    t_rdy  = 1'b1;
    waitAck(1'b1, 8, okHi);
    if (okHi) expQ.push_back(d);
    t_rdy = 1'b0;
    waitAck(1'b0, 8, okLo);
    ok = okHi && okLo;
  endtask

  task automatic popOne();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(expQ.pop_front());
  endtask

  task automatic test_reset();
    resetb_tclk = 1'b0;
    t_rdy = 1'b0;
    t_data = '0;
    rd_en = 1'b0;
    #12;
    checks++; if (r_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack got=%b exp=0", r_ack); end
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", rx_empty); end
    checks++; if (rx_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", rx_full); end
    checks++; if (rx_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", rx_count); end
    checks++; if (rd_underflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_underflow got=%b exp=0", rd_underflow); end
    @(negedge tclk);
    resetb_tclk = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    t_data = 32'hDEADBEEF;
    t_rdy  = 1'b1;
    tick();
    tick();
    checks++; if (r_ack !== 1'b0) begin failures++; $display("[TB] FAIL single_ack_e2 got=%b exp=0", r_ack); end
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("[TB] FAIL single_empty_e2 got=%b exp=1", rx_empty); end
    tick();
    expQ.push_back(32'hDEADBEEF);
    checks++; if (r_ack !== 1'b1) begin failures++; $display("[TB] FAIL single_ack_e3 got=%b exp=1", r_ack); end
    checks++; if (rd_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_data got=%h exp=deadbeef", rd_data); end
    checks++; if (rx_count !== 3'd1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", rx_count); end
    t_rdy = 1'b0;
    tick();
    tick();
    checks++; if (r_ack !== 1'b1) begin failures++; $display("[TB] FAIL single_ack_hold got=%b exp=1", r_ack); end
    tick();
    checks++; if (r_ack !== 1'b0) begin failures++; $display("[TB] FAIL single_ack_fall got=%b exp=0", r_ack); end
    checks++; if (rx_count !== 3'd1) begin failures++; $display("[TB] FAIL single_one_write got=%0d exp=1", rx_count); end
    popOne();
    checks++; if (rx_empty !== 1'b1) begin failures++; $display("[TB] FAIL single_drain got=%b exp=1", rx_empty); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] d5;
    for (int i = 0; i < DEPTH; i++) begin
      sendWord($urandom, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL bp_send%0d got=timeout exp=ack", i); end
    end
    checks++; if (rx_full !== 1'b1) begin failures++; $display("[TB] FAIL bp_full got=%b exp=1", rx_full); end
    d5 = $urandom;
    t_data = d5;
    t_rdy  = 1'b1;
    repeat (6) tick();
    checks++; if (r_ack !== 1'b0) begin failures++; $display("[TB] FAIL bp_stall_ack got=%b exp=0", r_ack); end
    checks++; if (rx_count !== 3'(expQ.size())) begin failures++; $display("[TB] FAIL bp_stall_count got=%0d exp=%0d", rx_count, expQ.size()); end
    checks++; if (rd_data !== expQ[0]) begin failures++; $display("[TB] FAIL bp_head got=%h exp=%h", rd_data, expQ[0]); end
    popOne();
    checks++; if (rx_count !== 3'd3) begin failures++; $display("[TB] FAIL bp_pop_nowrite got=%0d exp=3", rx_count); end
    checks++; if (r_ack !== 1'b0) begin failures++; $display("[TB] FAIL bp_pop_ack got=%b exp=0", r_ack); end
    tick();
    expQ.push_back(d5);
    checks++; if (r_ack !== 1'b1) begin failures++; $display("[TB] FAIL bp_fifth_ack got=%b exp=1", r_ack); end
    checks++; if (rx_count !== 3'd4) begin failures++; $display("[TB] FAIL bp_fifth_count got=%0d exp=4", rx_count); end
    t_rdy = 1'b0;
    waitAck(1'b0, 8, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL bp_release got=timeout exp=ack_low"); end
    while (expQ.size() > 0) begin
      checks++; if (rd_data !== expQ[0]) begin failures++; $display("[TB] FAIL bp_drain got=%h exp=%h", rd_data, expQ[0]); end
      popOne();
    end
  endtask

  task automatic test_order_wrap();
    bit ok;
    int popped = 0;
    int nPop;
    for (int i = 1; i <= 10; i++) begin
      if (expQ.size() == DEPTH) begin
        checks++; if (rd_data !== expQ[0]) begin failures++; $display("[TB] FAIL order_mkroom got=%h exp=%h", rd_data, expQ[0]); end
        popOne();
        popped++;
      end
      sendWord(32'(i), ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL order_send%0d got=timeout exp=ack", i); end
      nPop = $urandom_range(0, 2);
      for (int k = 0; k < nPop && expQ.size() > 0; k++) begin
        checks++; if (rd_data !== expQ[0]) begin failures++; $display("[TB] FAIL order_pop got=%h exp=%h", rd_data, expQ[0]); end
        popOne();
        popped++;
        checks++; if (rx_count !== 3'(expQ.size())) begin failures++; $display("[TB] FAIL order_count got=%0d exp=%0d", rx_count, expQ.size()); end
      end
    end
    while (expQ.size() > 0) begin
      checks++; if (rd_data !== expQ[0]) begin failures++; $display("[TB] FAIL order_drain got=%h exp=%h", rd_data, expQ[0]); end
      popOne();
      popped++;
    end
    checks++; if (popped != 10 || rx_empty !== 1'b1) begin failures++; $display("[TB] FAIL order_total got=%0d/%b exp=10/1", popped, rx_empty); end
  endtask

  task automatic test_push_pop();
    bit ok;
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      sendWord($urandom, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL pp_send%0d got=timeout exp=ack", i); end
    end
    d = $urandom;
    t_data = d;
    t_rdy  = 1'b1;
    tick();
    tick();
    checks++; if (r_ack !== 1'b0) begin failures++; $display("[TB] FAIL pp_pre_ack got=%b exp=0", r_ack); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    void'(expQ.pop_front());
    expQ.push_back(d);
    checks++; if (rx_count !== 3'd2) begin failures++; $display("[TB] FAIL pp_count got=%0d exp=2", rx_count); end
    checks++; if (r_ack !== 1'b1) begin failures++; $display("[TB] FAIL pp_ack got=%b exp=1", r_ack); end
    checks++; if (rd_data !== expQ[0]) begin failures++; $display("[TB] FAIL pp_head got=%h exp=%h", rd_data, expQ[0]); end
    t_rdy = 1'b0;
    waitAck(1'b0, 8, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL pp_release got=timeout exp=ack_low"); end
    while (expQ.size() > 0) begin
      checks++; if (rd_data !== expQ[0]) begin failures++; $display("[TB] FAIL pp_drain got=%h exp=%h", rd_data, expQ[0]); end
      popOne();
    end
  endtask

  task automatic test_underflow();
    checks++; if (rd_underflow !== 1'b0) begin failures++; $display("[TB] FAIL uf_idle got=%b exp=0", rd_underflow); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_underflow !== 1'b1) begin failures++; $display("[TB] FAIL uf_pulse got=%b exp=1", rd_underflow); end
    checks++; if (rx_count !== 3'd0 || rx_empty !== 1'b1) begin failures++; $display("[TB] FAIL uf_count got=%0d exp=0", rx_count); end
    tick();
    checks++; if (rd_underflow !== 1'b0) begin failures++; $display("[TB] FAIL uf_one_cycle got=%b exp=0", rd_underflow); end
  endtask

  task automatic test_reset_ack();
    bit ok;
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      sendWord($urandom, ok);
      checks++; if (!ok) begin failures++; $display("[TB] FAIL ra_send%0d got=timeout exp=ack", i); end
    end
    d = $urandom;
    t_data = d;
    t_rdy  = 1'b1;
    waitAck(1'b1, 8, ok);
    expQ.push_back(d);
    checks++; if (!ok || rx_count !== 3'd3) begin failures++; $display("[TB] FAIL ra_setup got=%b/%0d exp=1/3", r_ack, rx_count); end
    resetb_tclk = 1'b0;
    #1;
    expQ.delete();
    checks++; if (r_ack !== 1'b0) begin failures++; $display("[TB] FAIL ra_ack_async got=%b exp=0", r_ack); end
    checks++; if (rx_empty !== 1'b1 || rx_count !== 3'd0) begin failures++; $display("[TB] FAIL ra_flush got=%b/%0d exp=1/0", rx_empty, rx_count); end
    @(negedge tclk);
    resetb_tclk = 1'b1;
    waitAck(1'b1, 8, ok);
    if (ok) expQ.push_back(d);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL ra_reack got=timeout exp=ack"); end
    checks++; if (rd_data !== d || rx_count !== 3'd1) begin failures++; $display("[TB] FAIL ra_word got=%h/%0d exp=%h/1", rd_data, rx_count, d); end
    t_rdy = 1'b0;
    waitAck(1'b0, 8, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL ra_release got=timeout exp=ack_low"); end
    while (expQ.size() > 0) popOne();
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1 && expQ.size() < DEPTH) begin
        sendWord($urandom, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rnd_send got=timeout exp=ack"); end
      end else if (expQ.size() > 0) begin
        checks++; if (rd_data !== expQ[0]) begin failures++; $display("[TB] FAIL rnd_pop got=%h exp=%h", rd_data, expQ[0]); end
        popOne();
      end
      checks++; if (rx_count !== 3'(expQ.size()) || rx_full !== (expQ.size() == DEPTH)) begin
        failures++; $display("[TB] FAIL rnd_count got=%0d exp=%0d", rx_count, expQ.size());
      end
    end
    while (expQ.size() > 0) popOne();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_order_wrap();
    test_push_pop();
    test_underflow();
    test_reset_ack();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
